// File: rtl/riscv_core_icache_pkg.sv
// Shared types, widths and address helpers for the
// direct-mapped instruction cache controller.
package riscv_core_icache_pkg;

    localparam int ADDR_WIDTH     = 64;
    localparam int INDEX_WIDTH    = 7;
    localparam int LINE_OFF_WIDTH = 5;
    localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - LINE_OFF_WIDTH;
    localparam int CNT_WIDTH      = 32;
    localparam int NUM_SETS       = 1 << INDEX_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [TAG_WIDTH-1:0]   tag_t;
    typedef logic [CNT_WIDTH-1:0]   cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        AR_REQ,
        R_WAIT
    } state_e;

    function automatic index_t addr_index(input addr_t a);
        return a[LINE_OFF_WIDTH +: INDEX_WIDTH];
    endfunction

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_WIDTH-1 -: TAG_WIDTH];
    endfunction

    function automatic addr_t line_addr(input tag_t t, input index_t i);
        return {t, i, {LINE_OFF_WIDTH{1'b0}}};
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (&c) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/riscv_core_icache_tag_array.sv
// Tag registers and valid bits for the instruction cache:
// two combinational read ports, one write port, flush-all.
module riscv_core_icache_tag_array
    import riscv_core_icache_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  index_t i_idx_a,
    input  index_t i_idx_b,
    output tag_t   o_tag_a,
    output tag_t   o_tag_b,
    output logic   o_vld_a,
    output logic   o_vld_b,
    input  logic   i_we,
    input  index_t i_wr_idx,
    input  tag_t   i_wr_tag,
    input  logic   i_flush
);

    tag_t                tag_q [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] valid_d;

    assign o_tag_a = tag_q[i_idx_a];
    assign o_tag_b = tag_q[i_idx_b];
    assign o_vld_a = valid_q[i_idx_a];
    assign o_vld_b = valid_q[i_idx_b];

    // Install marks a line valid; a flush in the same cycle wins.
    always_comb begin
        valid_d = valid_q;
        if (i_we) begin
            valid_d[i_wr_idx] = 1'b1;
        end
        if (i_flush) begin
            valid_d = '0;
        end
    end

    // Valid vector; the only cache state that needs reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag storage, written on refill install.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            tag_q[i_wr_idx] <= i_wr_tag;
        end
    end

endmodule

// File: rtl/riscv_core_icache_controller.sv
// Direct-mapped I-cache controller: hit detection for
// (possibly line-straddling) fetches and AXI line refill.
module riscv_core_icache_controller
    import riscv_core_icache_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
    input  logic                  i_flush,
    output logic                  o_fetch_valid,
    output logic                  o_fetch_err,
    output logic                  o_stall,
    output logic                  o_mem_rd_en,
    output logic                  o_mem_wr_en,
    output logic                  o_mem_block_replace,
    output logic                  o_mem_offset,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    input  logic                  i_axi_rvalid,
    input  logic                  i_axi_rresp_err,
    output logic [CNT_WIDTH-1:0]  o_hit_cnt,
    output logic [CNT_WIDTH-1:0]  o_miss_cnt
);

    state_e state_q, state_d;
    index_t lat_idx_q, lat_idx_d;
    tag_t   lat_tag_q, lat_tag_d;
    logic   lat_off_q, lat_off_d;
    logic   flush_pend_q, flush_pend_d;
    logic   refilled_q, refilled_d;
    cnt_t   hit_cnt_q, hit_cnt_d;
    cnt_t   miss_cnt_q, miss_cnt_d;

    addr_t  addr_b;
    index_t idx_a, idx_b;
    tag_t   tag_a, tag_b;
    tag_t   rd_tag_a, rd_tag_b;
    logic   vld_a, vld_b;
    logic   hit_a, hit_b;
    logic   tag_we, tag_flush;

    // Line B holds the upper half of a fetch at offset 30.
    assign addr_b = i_fetch_addr + addr_t'(2);
    assign idx_a  = addr_index(i_fetch_addr);
    assign idx_b  = addr_index(addr_b);
    assign tag_a  = addr_tag(i_fetch_addr);
    assign tag_b  = addr_tag(addr_b);
    assign hit_a  = vld_a && (rd_tag_a == tag_a);
    assign hit_b  = vld_b && (rd_tag_b == tag_b);

    riscv_core_icache_tag_array u_tag_array (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_idx_a  (idx_a),
        .i_idx_b  (idx_b),
        .o_tag_a  (rd_tag_a),
        .o_tag_b  (rd_tag_b),
        .o_vld_a  (vld_a),
        .o_vld_b  (vld_b),
        .i_we     (tag_we),
        .i_wr_idx (lat_idx_q),
        .i_wr_tag (lat_tag_q),
        .i_flush  (tag_flush)
    );

    assign o_stall    = i_rst_n && i_fetch_req && !o_fetch_valid;
    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;

    // Lookup / refill sequencing and all datapath strobes.
    always_comb begin
        state_d             = state_q;
        lat_idx_d           = lat_idx_q;
        lat_tag_d           = lat_tag_q;
        lat_off_d           = lat_off_q;
        flush_pend_d        = flush_pend_q;
        refilled_d          = refilled_q;
        hit_cnt_d           = hit_cnt_q;
        miss_cnt_d          = miss_cnt_q;
        tag_we              = 1'b0;
        tag_flush           = 1'b0;
        o_fetch_valid       = 1'b0;
        o_fetch_err         = 1'b0;
        o_mem_rd_en         = 1'b0;
        o_mem_wr_en         = 1'b0;
        o_mem_block_replace = 1'b0;
        o_mem_offset        = 1'b0;
        o_axi_arvalid       = 1'b0;
        o_axi_araddr        = '0;
        unique case (state_q)
            IDLE: begin
                if (!i_fetch_req) begin
                    refilled_d = 1'b0;
                end
                if (i_flush) begin
                    tag_flush = 1'b1;
                end else if (i_fetch_req) begin
                    if (hit_a && hit_b) begin
                        o_mem_rd_en   = 1'b1;
                        o_fetch_valid = 1'b1;
                        refilled_d    = 1'b0;
                        if (!refilled_q) begin
                            hit_cnt_d = sat_inc(hit_cnt_q);
                        end
                    end else begin
                        lat_idx_d  = hit_a ? idx_b : idx_a;
                        lat_tag_d  = hit_a ? tag_b : tag_a;
                        lat_off_d  = hit_a;
                        refilled_d = 1'b1;
                        state_d    = AR_REQ;
                    end
                end
            end
            AR_REQ: begin
                o_axi_arvalid = 1'b1;
                o_axi_araddr  = line_addr(lat_tag_q, lat_idx_q);
                if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (i_axi_arready) begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    state_d    = R_WAIT;
                end
            end
            R_WAIT: begin
                if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (i_axi_rvalid) begin
                    if (i_axi_rresp_err) begin
                        o_fetch_err = 1'b1;
                        refilled_d  = 1'b0;
                    end else begin
                        o_mem_wr_en         = 1'b1;
                        o_mem_block_replace = 1'b1;
                        o_mem_offset        = lat_off_q;
                        tag_we              = 1'b1;
                    end
                    tag_flush    = flush_pend_q || i_flush;
                    flush_pend_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            lat_idx_q    <= '0;
            lat_tag_q    <= '0;
            lat_off_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            refilled_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            lat_idx_q    <= lat_idx_d;
            lat_tag_q    <= lat_tag_d;
            lat_off_q    <= lat_off_d;
            flush_pend_q <= flush_pend_d;
            refilled_q   <= refilled_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_core_icache_controller.sv
// Bench for the I-cache controller: directed table, corner
// sequences and random fetches against a line-level model.
module tb_riscv_core_icache_controller;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        flush;
    logic        fetch_valid, fetch_err, stall;
    logic        mem_rd_en, mem_wr_en, mem_br, mem_off;
    logic        arvalid, arready;
    logic [63:0] araddr;
    logic        rvalid, rresp_err;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    int ar_dly = 1;
    int r_dly  = 1;
    bit err_next = 0;
    int sl_st = 0;
    int sl_cnt = 0;
    logic [63:0] aq[$];
    int          wq[$];

    riscv_core_icache_controller dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_fetch_req         (fetch_req),
        .i_fetch_addr        (fetch_addr),
        .i_flush             (flush),
        .o_fetch_valid       (fetch_valid),
        .o_fetch_err         (fetch_err),
        .o_stall             (stall),
        .o_mem_rd_en         (mem_rd_en),
        .o_mem_wr_en         (mem_wr_en),
        .o_mem_block_replace (mem_br),
        .o_mem_offset        (mem_off),
        .o_axi_arvalid       (arvalid),
        .i_axi_arready       (arready),
        .o_axi_araddr        (araddr),
        .i_axi_rvalid        (rvalid),
        .i_axi_rresp_err     (rresp_err),
        .o_hit_cnt           (hit_cnt),
        .o_miss_cnt          (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // AXI read slave: arready after ar_dly+1 cycles, rvalid after r_dly.
    initial begin
        arready = 0;
        rvalid = 0;
        rresp_err = 0;
        forever begin
            @(posedge clk);
            #1;
            arready = 0;
            rvalid = 0;
            rresp_err = 0;
            if (!rst_n) begin
                sl_st = 0;
            end else begin
                case (sl_st)
                    0: if (arvalid) begin
                        sl_cnt = ar_dly;
                        sl_st = 1;
                    end
                    1: if (sl_cnt == 0) begin
                        arready = 1;
                        aq.push_back(araddr);
                        sl_cnt = r_dly;
                        sl_st = 2;
                    end else sl_cnt--;
                    2: if (sl_cnt == 0) begin
                        rvalid = 1;
                        rresp_err = err_next;
                        sl_st = 0;
                    end else sl_cnt--;
                    default: sl_st = 0;
                endcase
            end
        end
    end

    logic        p_arv = 0;
    logic        p_ard = 0;
    logic [63:0] p_addr = 0;

    // Protocol monitor: write strobes, AR stability, rd/valid pairing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en) wq.push_back(int'(mem_off));
            if (mem_wr_en || mem_br)
                chk("wr_vs_replace", 64'(mem_wr_en), 64'(mem_br));
            if (mem_rd_en || fetch_valid)
                chk("rd_vs_valid", 64'(mem_rd_en), 64'(fetch_valid));
            if (p_arv && !p_ard) begin
                chk("ar_hold_valid", 64'(arvalid), 64'd1);
                chk("ar_hold_addr", araddr, p_addr);
            end
        end
        p_arv = rst_n && arvalid;
        p_ard = arready;
        p_addr = araddr;
    end

    // Issue one fetch and hold it until valid or error.
    task automatic do_fetch(input logic [63:0] a, input bit fl,
                            output int lat, output bit got_err);
        bit pend;
        bit done_fl;
        pend = 0;
        done_fl = 0;
        lat = -1;
        got_err = 0;
        fetch_addr = a;
        fetch_req = 1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (fetch_valid) begin
                lat = n;
                break;
            end
            if (fetch_err) begin
                lat = n;
                got_err = 1;
                break;
            end
            if (fl && !done_fl && arvalid && arready) begin
                pend = 1;
                done_fl = 1;
            end
            @(posedge clk);
            #1;
            flush = pend;
            pend = 0;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: addr %0h no response", a);
        end
        @(posedge clk);
        #1;
        fetch_req = 0;
        flush = 0;
    endtask

    bit          mv [128];
    logic [51:0] mt [128];
    int          m_hit, m_miss;

    // Cache model at line granularity: line number = addr >> 5.
    task automatic model_fetch(input logic [63:0] a, output int n,
                               output logic [63:0] ar0, output logic [63:0] ar1,
                               output int of0, output int of1);
        logic [63:0] ln;
        logic [63:0] lna;
        logic [63:0] lnb;
        int idx;
        lna = a >> 5;
        lnb = (a + 64'd2) >> 5;
        n = 0;
        ar0 = 0;
        ar1 = 0;
        of0 = 0;
        of1 = 0;
        for (int k = 0; k < 2; k++) begin
            ln = (k == 0) ? lna : lnb;
            if (k == 0 || lnb != lna) begin
                idx = int'(ln % 128);
                if (!(mv[idx] && mt[idx] == 52'(ln / 128))) begin
                    if (n == 0) begin
                        ar0 = ln * 32;
                        of0 = k;
                    end else begin
                        ar1 = ln * 32;
                        of1 = k;
                    end
                    n++;
                    mv[idx] = 1;
                    mt[idx] = 52'(ln / 128);
                end
            end
        end
        if (n == 0) m_hit++;
        m_miss += n;
    endtask

    typedef struct {
        logic [63:0] addr;
        int          nref;
        logic [63:0] ar0;
        logic [63:0] ar1;
        int          off0;
        int          hit;
        int          miss;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lat;
        bit e;
        int n, of0, of1;
        logic [63:0] a0, a1, ra;

        rst_n = 0;
        fetch_req = 0;
        fetch_addr = 0;
        flush = 0;

        tbl[0] = '{64'h1000, 1, 64'h1000, 64'h0, 0, 0, 1};
        tbl[1] = '{64'h1004, 0, 64'h0, 64'h0, 0, 1, 1};
        tbl[2] = '{64'h201E, 2, 64'h2000, 64'h2020, 0, 1, 3};
        tbl[3] = '{64'h1000, 1, 64'h1000, 64'h0, 0, 1, 4};
        tbl[4] = '{64'h2024, 0, 64'h0, 64'h0, 0, 2, 4};
        tbl[5] = '{64'h3FFE, 2, 64'h3FE0, 64'h4000, 0, 2, 6};
        tbl[6] = '{64'h1002, 1, 64'h1000, 64'h0, 0, 2, 7};
        tbl[7] = '{64'h101E, 1, 64'h1020, 64'h0, 1, 2, 8};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_valid", 64'(fetch_valid), 0);
        chk("rst_wr", 64'(mem_wr_en), 0);
        chk("rst_hit_cnt", 64'(hit_cnt), 0);
        chk("rst_miss_cnt", 64'(miss_cnt), 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            aq.delete();
            wq.delete();
            do_fetch(tbl[i].addr, 0, lat, e);
            chk($sformatf("t%0d_nref", i), 64'(aq.size()), 64'(tbl[i].nref));
            chk($sformatf("t%0d_nwr", i), 64'(wq.size()), 64'(tbl[i].nref));
            if (tbl[i].nref >= 1 && aq.size() >= 1 && wq.size() >= 1) begin
                chk($sformatf("t%0d_ar0", i), aq[0], tbl[i].ar0);
                chk($sformatf("t%0d_off0", i), 64'(wq[0]), 64'(tbl[i].off0));
            end
            if (tbl[i].nref == 2 && aq.size() >= 2 && wq.size() >= 2) begin
                chk($sformatf("t%0d_ar1", i), aq[1], tbl[i].ar1);
                chk($sformatf("t%0d_off1", i), 64'(wq[1]), 64'd1);
            end
            if (tbl[i].nref == 0)
                chk($sformatf("t%0d_hit_lat", i), 64'(lat), 0);
            chk($sformatf("t%0d_hit_cnt", i), 64'(hit_cnt), 64'(tbl[i].hit));
            chk($sformatf("t%0d_miss_cnt", i), 64'(miss_cnt), 64'(tbl[i].miss));
        end

        // Flush together with a fetch to a resident line.
        aq.delete();
        fetch_addr = 64'h1000;
        fetch_req = 1;
        flush = 1;
        @(negedge clk);
        chk("flush_same_cycle_valid", 64'(fetch_valid), 0);
        chk("flush_same_cycle_rd", 64'(mem_rd_en), 0);
        @(posedge clk);
        #1;
        flush = 0;
        do_fetch(64'h1000, 0, lat, e);
        chk("flush_idle_refill", 64'(aq.size()), 1);
        aq.delete();
        do_fetch(64'h1024, 0, lat, e);
        chk("flush_idle_other_line", 64'(aq.size()), 1);
        chk("flush_idle_miss_cnt", 64'(miss_cnt), 10);

        // Flush while the refill is in flight.
        aq.delete();
        r_dly = 2;
        do_fetch(64'h5000, 1, lat, e);
        chk("flush_rwait_nref", 64'(aq.size()), 2);
        aq.delete();
        do_fetch(64'h5000, 0, lat, e);
        chk("flush_rwait_rehit", 64'(aq.size()), 0);
        chk("flush_rwait_lat", 64'(lat), 0);
        chk("flush_rwait_hit_cnt", 64'(hit_cnt), 3);
        chk("flush_rwait_miss_cnt", 64'(miss_cnt), 12);

        // Error response: no install, single-cycle error pulse.
        aq.delete();
        wq.delete();
        err_next = 1;
        do_fetch(64'h6000, 0, lat, e);
        err_next = 0;
        chk("err_flag", 64'(e), 1);
        chk("err_no_write", 64'(wq.size()), 0);
        @(negedge clk);
        chk("err_one_cycle", 64'(fetch_err), 0);
        @(posedge clk);
        #1;
        aq.delete();
        wq.delete();
        do_fetch(64'h6000, 0, lat, e);
        chk("err_line_invalid", 64'(aq.size()), 1);
        chk("err_retry_ok", 64'(e), 0);
        chk("err_miss_cnt", 64'(miss_cnt), 14);

        // Reset while waiting for read data.
        r_dly = 8;
        fetch_addr = 64'h7000;
        fetch_req = 1;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (arvalid && arready) begin
                n = 1;
                break;
            end
        end
        chk("rst_rwait_reached", 64'(n), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        fetch_req = 0;
        #1;
        chk("rstw_arvalid", 64'(arvalid), 0);
        chk("rstw_araddr", araddr, 0);
        chk("rstw_wr", 64'(mem_wr_en), 0);
        chk("rstw_stall", 64'(stall), 0);
        chk("rstw_err", 64'(fetch_err), 0);
        chk("rstw_hit_cnt", 64'(hit_cnt), 0);
        chk("rstw_miss_cnt", 64'(miss_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        r_dly = 1;
        @(posedge clk);
        #1;

        // Random fetches against the line model.
        for (int i = 0; i < 128; i++) mv[i] = 0;
        m_hit = 0;
        m_miss = 0;
        for (int i = 0; i < 150; i++) begin
            ar_dly = int'($urandom_range(0, 3));
            r_dly = int'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                flush = 1;
                @(posedge clk);
                #1;
                flush = 0;
                for (int k = 0; k < 128; k++) mv[k] = 0;
            end
            ra = 64'($urandom_range(0, 3)) << 12;
            ra = ra | (64'($urandom_range(0, 127)) << 5);
            if ($urandom_range(0, 3) == 0) ra = ra | 64'd30;
            else ra = ra | (64'($urandom_range(0, 15)) << 1);
            model_fetch(ra, n, a0, a1, of0, of1);
            aq.delete();
            wq.delete();
            do_fetch(ra, 0, lat, e);
            chk("rnd_nref", 64'(aq.size()), 64'(n));
            if (n >= 1 && aq.size() >= 1 && wq.size() >= 1) begin
                chk("rnd_ar0", aq[0], a0);
                chk("rnd_off0", 64'(wq[0]), 64'(of0));
            end
            if (n == 2 && aq.size() >= 2 && wq.size() >= 2) begin
                chk("rnd_ar1", aq[1], a1);
                chk("rnd_off1", 64'(wq[1]), 64'(of1));
            end
            if (n == 0) chk("rnd_hit_lat", 64'(lat), 0);
        end
        chk("rnd_hit_cnt", 64'(hit_cnt), 64'(m_hit));
        chk("rnd_miss_cnt", 64'(miss_cnt), 64'(m_miss));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
